// File: rtl/letc_core_dmcache.sv
// Direct-mapped, write-through, no-write-allocate cache between a stage LIMP port and the AXI FSM LIMP port.
// Optional hit/miss performance counters are enabled with `define LETC_CORE_DMCACHE_PERF_EN.
module letc_core_dmcache #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush_cache,

    input  logic        stage_limp_valid,
    output logic        stage_limp_ready,
    input  logic        stage_limp_wen_nren,
    input  logic [1:0]  stage_limp_size,
    input  logic [33:0] stage_limp_addr,
    output logic [31:0] stage_limp_rdata,
    input  logic [31:0] stage_limp_wdata,

    output logic        axi_fsm_limp_valid,
    input  logic        axi_fsm_limp_ready,
    output logic        axi_fsm_limp_wen_nren,
    output logic [1:0]  axi_fsm_limp_size,
    output logic [33:0] axi_fsm_limp_addr,
    input  logic [31:0] axi_fsm_limp_rdata,
    output logic [31:0] axi_fsm_limp_wdata
`ifdef LETC_CORE_DMCACHE_PERF_EN
    ,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
`endif
);

    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int LW_BITS  = $clog2(LINE_WORDS);
    localparam int WSEL_W   = (LW_BITS > 0) ? LW_BITS : 1;
    localparam int LINE_LSB = 2 + LW_BITS;
    localparam int TAG_LSB  = LINE_LSB + IDX_W;
    localparam int TAG_W    = 34 - TAG_LSB;

    localparam logic [1:0] SIZE_BYTE     = 2'd0;
    localparam logic [1:0] SIZE_HALFWORD = 2'd1;
    localparam logic [1:0] SIZE_WORD     = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_WRITE
    } state_e;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  offset
    );
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SIZE_BYTE:     merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            SIZE_HALFWORD: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default:       merged = wdata;
        endcase
        return merged;
    endfunction

    state_e              state_q, state_d;
    logic [WSEL_W-1:0]   cnt_q, cnt_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                flush_pending_q, flush_pending_d;
    logic                axi_valid_q, axi_valid_d;
    logic                axi_wen_q, axi_wen_d;
    logic [1:0]          axi_size_q, axi_size_d;
    logic [33:0]         axi_addr_q, axi_addr_d;
    logic [31:0]         axi_wdata_q, axi_wdata_d;
    logic [TAG_W-1:0]    tag_q  [NUM_LINES];
    logic [TAG_W-1:0]    tag_d  [NUM_LINES];
    logic [31:0]         data_q [NUM_LINES][LINE_WORDS];
    logic [31:0]         data_d [NUM_LINES][LINE_WORDS];
`ifdef LETC_CORE_DMCACHE_PERF_EN
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;
`endif

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_word;
    logic [33:0]       line_base;
    logic              hit;
    logic              flush_req;

    assign req_idx   = stage_limp_addr[LINE_LSB +: IDX_W];
    assign req_tag   = stage_limp_addr[33 -: TAG_W];
    assign line_base = stage_limp_addr & ~34'(LINE_WORDS * 4 - 1);
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign flush_req = i_flush_cache || flush_pending_q;

    generate
        if (LW_BITS > 0) begin : g_word_sel
            assign req_word = stage_limp_addr[2 +: WSEL_W];
        end else begin : g_word_sel_single
            assign req_word = '0;
        end
    endgenerate

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        valid_d          = valid_q;
        flush_pending_d  = flush_pending_q;
        axi_valid_d      = axi_valid_q;
        axi_wen_d        = axi_wen_q;
        axi_size_d       = axi_size_q;
        axi_addr_d       = axi_addr_q;
        axi_wdata_d      = axi_wdata_q;
        tag_d            = tag_q;
        data_d           = data_q;
        stage_limp_ready = 1'b0;
        stage_limp_rdata = '0;
`ifdef LETC_CORE_DMCACHE_PERF_EN
        hit_count_d      = hit_count_q;
        miss_count_d     = miss_count_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (stage_limp_valid && !stage_limp_wen_nren && hit) begin
                    stage_limp_ready = 1'b1;
                    stage_limp_rdata = data_q[req_idx][req_word];
                    // A flush cannot clear the line being returned this cycle; defer it.
                    if (flush_req) flush_pending_d = 1'b1;
`ifdef LETC_CORE_DMCACHE_PERF_EN
                    hit_count_d = hit_count_q + 32'd1;
`endif
                end else begin
                    if (flush_req) begin
                        valid_d         = '0;
                        flush_pending_d = 1'b0;
                    end
                    if (stage_limp_valid && !stage_limp_wen_nren) begin
                        state_d     = ST_REFILL;
                        cnt_d       = '0;
                        axi_valid_d = 1'b1;
                        axi_wen_d   = 1'b0;
                        axi_size_d  = SIZE_WORD;
                        axi_addr_d  = line_base;
                        axi_wdata_d = '0;
`ifdef LETC_CORE_DMCACHE_PERF_EN
                        miss_count_d = miss_count_q + 32'd1;
`endif
                    end else if (stage_limp_valid) begin
                        state_d     = ST_WRITE;
                        axi_valid_d = 1'b1;
                        axi_wen_d   = 1'b1;
                        axi_size_d  = stage_limp_size;
                        axi_addr_d  = stage_limp_addr;
                        axi_wdata_d = stage_limp_wdata;
                    end
                end
            end

            ST_REFILL: begin
                if (i_flush_cache) flush_pending_d = 1'b1;
                if (axi_fsm_limp_ready) begin
                    data_d[req_idx][cnt_q] = axi_fsm_limp_rdata;
                    if (cnt_q == WSEL_W'(LINE_WORDS - 1)) begin
                        tag_d[req_idx]   = req_tag;
                        valid_d[req_idx] = 1'b1;
                        state_d          = ST_IDLE;
                        cnt_d            = '0;
                        axi_valid_d      = 1'b0;
                        if (flush_req) begin
                            valid_d         = '0;
                            flush_pending_d = 1'b0;
                        end
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        axi_addr_d = line_base + (34'(cnt_q + 1'b1) << 2);
                    end
                end
            end

            ST_WRITE: begin
                if (i_flush_cache) flush_pending_d = 1'b1;
                if (axi_fsm_limp_ready) begin
                    stage_limp_ready = 1'b1;
                    if (hit) begin
                        data_d[req_idx][req_word] = merge_bytes(data_q[req_idx][req_word],
                            stage_limp_wdata, stage_limp_size, stage_limp_addr[1:0]);
                    end
                    state_d     = ST_IDLE;
                    axi_valid_d = 1'b0;
                    axi_wen_d   = 1'b0;
                    if (flush_req) begin
                        valid_d         = '0;
                        flush_pending_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                axi_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            axi_valid_q     <= 1'b0;
            axi_wen_q       <= 1'b0;
            axi_size_q      <= '0;
            axi_addr_q      <= '0;
            axi_wdata_q     <= '0;
`ifdef LETC_CORE_DMCACHE_PERF_EN
            hit_count_q     <= '0;
            miss_count_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            valid_q         <= valid_d;
            flush_pending_q <= flush_pending_d;
            axi_valid_q     <= axi_valid_d;
            axi_wen_q       <= axi_wen_d;
            axi_size_q      <= axi_size_d;
            axi_addr_q      <= axi_addr_d;
            axi_wdata_q     <= axi_wdata_d;
`ifdef LETC_CORE_DMCACHE_PERF_EN
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
`endif
        end
    end

    // Tag and data storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge i_clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign axi_fsm_limp_valid    = axi_valid_q;
    assign axi_fsm_limp_wen_nren = axi_wen_q;
    assign axi_fsm_limp_size     = axi_size_q;
    assign axi_fsm_limp_addr     = axi_addr_q;
    assign axi_fsm_limp_wdata    = axi_wdata_q;

`ifdef LETC_CORE_DMCACHE_PERF_EN
    assign o_hit_count  = hit_count_q;
    assign o_miss_count = miss_count_q;
`else
`endif

endmodule

// File: tb/tb_letc_core_dmcache.sv
// Directed bench for letc_core_dmcache (NUM_LINES=16, LINE_WORDS=4); backing memory returns ~addr.
module tb_letc_core_dmcache;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_wen = 1'b0;
    logic [1:0]  s_size = SZ_W;
    logic [33:0] s_addr = '0;
    logic [31:0] s_rdata;
    logic [31:0] s_wdata = '0;
    logic        a_valid;
    logic        a_ready;
    logic        a_wen;
    logic [1:0]  a_size;
    logic [33:0] a_addr;
    logic [31:0] a_rdata;
    logic [31:0] a_wdata;
`ifdef LETC_CORE_DMCACHE_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    logic        alt_mode = 1'b0;
    logic        tog = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [33:0] rd_log [$];
    logic [33:0] wr_addr_last = '0;
    logic [1:0]  wr_size_last = '0;
    logic [31:0] wr_data_last = '0;
    int          n_assert = 0;
    int          n_fail = 0;

    letc_core_dmcache #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_flush_cache         (flush),
        .stage_limp_valid      (s_valid),
        .stage_limp_ready      (s_ready),
        .stage_limp_wen_nren   (s_wen),
        .stage_limp_size       (s_size),
        .stage_limp_addr       (s_addr),
        .stage_limp_rdata      (s_rdata),
        .stage_limp_wdata      (s_wdata),
        .axi_fsm_limp_valid    (a_valid),
        .axi_fsm_limp_ready    (a_ready),
        .axi_fsm_limp_wen_nren (a_wen),
        .axi_fsm_limp_size     (a_size),
        .axi_fsm_limp_addr     (a_addr),
        .axi_fsm_limp_rdata    (a_rdata),
        .axi_fsm_limp_wdata    (a_wdata)
`ifdef LETC_CORE_DMCACHE_PERF_EN
        ,
        .o_hit_count           (hit_count),
        .o_miss_count          (miss_count)
`endif
    );

    always #5 clk = ~clk;

    assign a_rdata = ~a_addr[31:0];
    assign a_ready = alt_mode ? tog : 1'b1;

    always @(posedge clk) begin
        tog <= ~tog;
        if (a_valid && a_ready) begin
            if (!a_wen) begin
                rd_cnt <= rd_cnt + 1;
                rd_log.push_back(a_addr);
            end else begin
                wr_cnt       <= wr_cnt + 1;
                wr_addr_last <= a_addr;
                wr_size_last <= a_size;
                wr_data_last <= a_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic read_req(input logic [33:0] addr, output logic [31:0] data, output int cyc);
        logic got;
        got = 1'b0;
        data = '0;
        cyc = 0;
        s_valid = 1'b1;
        s_wen = 1'b0;
        s_size = SZ_W;
        s_addr = addr;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_ready) begin
                got = 1'b1;
                data = s_rdata;
            end
        end
        check("read_done", 64'(got), 64'd1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic write_req(input logic [33:0] addr, input logic [1:0] size,
                             input logic [31:0] wd, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        s_valid = 1'b1;
        s_wen = 1'b1;
        s_size = size;
        s_addr = addr;
        s_wdata = wd;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_ready) got = 1'b1;
        end
        check("write_done", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_wen = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int cyc;
        int rd0;
        int wr0;
        logic seen;

        repeat (3) @(negedge clk);
        check("rst_stage_ready", 64'(s_ready), 64'd0);
        check("rst_axi_valid", 64'(a_valid), 64'd0);
        check("rst_rdata", 64'(s_rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_axi_valid", 64'(a_valid), 64'd0);
`ifdef LETC_CORE_DMCACHE_PERF_EN
        check("rst_hit_count", 64'(hit_count), 64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
`endif

        // Cold read miss: four-word refill then hit.
        rd0 = rd_cnt;
        read_req(34'h0ABCD1234, d, cyc);
        check("miss_rdata", 64'(d), 64'h5432EDCB);
        check("miss_cycles", 64'(cyc), 64'd6);
        check("miss_axi_reads", 64'(rd_cnt - rd0), 64'd4);
        check("refill_addr0", 64'(rd_log[0]), 64'h0ABCD1230);
        check("refill_addr1", 64'(rd_log[1]), 64'h0ABCD1234);
        check("refill_addr2", 64'(rd_log[2]), 64'h0ABCD1238);
        check("refill_addr3", 64'(rd_log[3]), 64'h0ABCD123C);

        rd0 = rd_cnt;
        read_req(34'h0ABCD1234, d, cyc);
        check("hit_rdata", 64'(d), 64'h5432EDCB);
        check("hit_cycles", 64'(cyc), 64'd1);
        check("hit_axi_reads", 64'(rd_cnt - rd0), 64'd0);

        rd0 = rd_cnt;
        read_req(34'h0ABCD1238, d, cyc);
        check("hit2_rdata", 64'(d), 64'h5432EDC7);
        check("hit2_cycles", 64'(cyc), 64'd1);
        check("hit2_axi_reads", 64'(rd_cnt - rd0), 64'd0);

        // Conflicting tag on line 3 evicts it.
        rd0 = rd_cnt;
        read_req(34'h011111234, d, cyc);
        check("evict_rdata", 64'(d), 64'hEEEEEDCB);
        check("evict_axi_reads", 64'(rd_cnt - rd0), 64'd4);
        rd0 = rd_cnt;
        read_req(34'h0ABCD1234, d, cyc);
        check("remiss_cycles", 64'(cyc), 64'd6);
        check("remiss_axi_reads", 64'(rd_cnt - rd0), 64'd4);

        // Byte write into a resident line.
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        write_req(34'h0ABCD1235, SZ_B, 32'h000000A5, cyc);
        check("wb_cycles", 64'(cyc), 64'd2);
        check("wb_axi_writes", 64'(wr_cnt - wr0), 64'd1);
        check("wb_axi_reads", 64'(rd_cnt - rd0), 64'd0);
        check("wb_axi_addr", 64'(wr_addr_last), 64'h0ABCD1235);
        check("wb_axi_size", 64'(wr_size_last), 64'(SZ_B));
        check("wb_axi_wdata", 64'(wr_data_last), 64'h000000A5);
        read_req(34'h0ABCD1234, d, cyc);
        check("wb_merged", 64'(d), 64'h5432A5CB);
        check("wb_merged_cycles", 64'(cyc), 64'd1);

        // Halfword write into the upper half of word 2.
        write_req(34'h0ABCD123A, SZ_H, 32'h0000BEEF, cyc);
        check("wh_axi_size", 64'(wr_size_last), 64'(SZ_H));
        check("wh_axi_wdata", 64'(wr_data_last), 64'h0000BEEF);
        read_req(34'h0ABCD1238, d, cyc);
        check("wh_merged", 64'(d), 64'hBEEFEDC7);

        // Write miss goes through without allocating.
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        write_req(34'h022220000, SZ_W, 32'hDEADBEEF, cyc);
        check("wmiss_axi_writes", 64'(wr_cnt - wr0), 64'd1);
        check("wmiss_axi_reads", 64'(rd_cnt - rd0), 64'd0);
        check("wmiss_axi_addr", 64'(wr_addr_last), 64'h022220000);
        check("wmiss_axi_wdata", 64'(wr_data_last), 64'hDEADBEEF);
        rd0 = rd_cnt;
        read_req(34'h022220000, d, cyc);
        check("wmiss_read_rdata", 64'(d), 64'hDDDDFFFF);
        check("wmiss_read_axi_reads", 64'(rd_cnt - rd0), 64'd4);

        // Flush during a slow refill: line invalidated on completion, read re-misses.
        alt_mode = 1'b1;
        rd0 = rd_cnt;
        seen = 1'b0;
        fork
            read_req(34'h033330010, d, cyc);
            begin
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (a_valid) seen = 1'b1;
                end
                @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join
        check("flush_refill_seen", 64'(seen), 64'd1);
        check("flush_rdata", 64'(d), 64'hCCCCFFEF);
        check("flush_axi_reads", 64'(rd_cnt - rd0), 64'd8);
        rd0 = rd_cnt;
        read_req(34'h033330010, d, cyc);
        check("post_flush_hit_cycles", 64'(cyc), 64'd1);
        check("post_flush_hit_axi", 64'(rd_cnt - rd0), 64'd0);
        alt_mode = 1'b0;

        // Idle flush clears everything.
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        rd0 = rd_cnt;
        read_req(34'h033330010, d, cyc);
        check("idle_flush_cycles", 64'(cyc), 64'd6);
        check("idle_flush_axi_reads", 64'(rd_cnt - rd0), 64'd4);
        check("idle_flush_rdata", 64'(d), 64'hCCCCFFEF);

`ifdef LETC_CORE_DMCACHE_PERF_EN
        check("perf_hits", 64'(hit_count), 64'd11);
        check("perf_misses", 64'(miss_count), 64'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
